// File: rtl/fifo_sync_flow.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and
// write-through-when-full; sticky overflow/underflow flags under FIFO_SYNC_FLOW_ERR_FLAG_EN.
module fifo_sync_flow #(
    parameter int BIT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           write_en,
    input  logic [BIT_WIDTH-1:0]           write_data,
    input  logic                           read_en,
    output logic [BIT_WIDTH-1:0]           read_data,
    output logic                           fifo_empty,
    output logic                           fifo_full,
    output logic                           fifo_almost_empty,
    output logic                           fifo_almost_full,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    input  logic                           err_clr,
    output logic                           fifo_overflow,
    output logic                           fifo_underflow
);

    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = ADDR_WIDTH + 1;

    logic [BIT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  aempty_q, aempty_d;
    logic                  afull_q, afull_d;
    logic                  wr_acc, rd_acc;

    // A write into a full FIFO is accepted when the head is consumed in the same cycle.
    always_comb begin
        wr_acc   = write_en & (~full_q | read_en);
        rd_acc   = read_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_acc);
        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_W'(FIFO_DEPTH));
        aempty_d = (count_d <= CNT_W'(AE_THRESH));
        afull_d  = (count_d >= CNT_W'(AF_THRESH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    assign read_data         = empty_q ? '0 : mem_q[rd_ptr_q];
    assign fifo_empty        = empty_q;
    assign fifo_full         = full_q;
    assign fifo_almost_empty = aempty_q;
    assign fifo_almost_full  = afull_q;
    assign fifo_count        = count_q;

`ifdef FIFO_SYNC_FLOW_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A new event in the clearing cycle keeps the flag set.
    always_comb begin
        ovf_d = (write_en & ~wr_acc) | (ovf_q & ~err_clr);
        unf_d = (read_en & ~rd_acc) | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = unf_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && write_en && !wr_acc) $display("fifo_sync_flow: write rejected (overflow) at %0t", $time);
        if (rst_n && read_en && !rd_acc) $display("fifo_sync_flow: read rejected (underflow) at %0t", $time);
    end
`endif
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign fifo_overflow  = 1'b0;
    assign fifo_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_flow.sv
// Directed bench for fifo_sync_flow (DEPTH 8, AF 7, AE 1) plus a short queue-checked random burst.
module tb_fifo_sync_flow;

`ifdef FIFO_SYNC_FLOW_ERR_FLAG_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       write_en;
    logic [7:0] write_data;
    logic       read_en;
    logic [7:0] read_data;
    logic       fifo_empty, fifo_full, fifo_almost_empty, fifo_almost_full;
    logic [3:0] fifo_count;
    logic       err_clr;
    logic       fifo_overflow, fifo_underflow;

    int checks   = 0;
    int failures = 0;

    fifo_sync_flow #(
        .BIT_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(7), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(read_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_almost_empty(fifo_almost_empty), .fifo_almost_full(fifo_almost_full),
        .fifo_count(fifo_count),
        .err_clr(err_clr),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock edge, then settle just after it.
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ec);
        write_en   = we;
        write_data = wd;
        read_en    = re;
        err_clr    = ec;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 0);
        check({tag, "_empty"}, 32'(fifo_empty), 1);
        check({tag, "_full"},  32'(fifo_full), 0);
        check({tag, "_ae"},    32'(fifo_almost_empty), 1);
        check({tag, "_af"},    32'(fifo_almost_full), 0);
        check({tag, "_ovf"},   32'(fifo_overflow), 0);
        check({tag, "_unf"},   32'(fifo_underflow), 0);
        check({tag, "_rdata"}, 32'(read_data), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic       we, re, full_m, wacc, racc;
        logic [7:0] wd, exp_rd;

        rst_n = 1'b0; write_en = 1'b0; write_data = '0; read_en = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            check($sformatf("fill%0d_count", i), 32'(fifo_count), i);
            check($sformatf("fill%0d_ae", i), 32'(fifo_almost_empty), (i <= 1) ? 1 : 0);
            check($sformatf("fill%0d_af", i), 32'(fifo_almost_full), (i >= 7) ? 1 : 0);
            check($sformatf("fill%0d_full", i), 32'(fifo_full), (i == 8) ? 1 : 0);
            check($sformatf("fill%0d_empty", i), 32'(fifo_empty), 0);
            check($sformatf("fill%0d_rdata", i), 32'(read_data), 32'h01);
        end

        // Write into full without read: rejected
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_count", 32'(fifo_count), 8);
        check("ovf_rdata", 32'(read_data), 32'h01);
        check("ovf_flag", 32'(fifo_overflow), 32'(ERR_ON));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(fifo_overflow), 0);

        // Full with simultaneous read and write: head drains 1..8, 0x55 refills
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("rw%0d_head", k), 32'(read_data), k);
            step(1'b1, 8'h55, 1'b1, 1'b0);
            check($sformatf("rw%0d_count", k), 32'(fifo_count), 8);
            check($sformatf("rw%0d_full", k), 32'(fifo_full), 1);
            check($sformatf("rw%0d_ovf", k), 32'(fifo_overflow), 0);
        end
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain%0d_head", k), 32'(read_data), 32'h55);
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("drain%0d_count", k), 32'(fifo_count), 8 - k);
        end
        check("drain_empty", 32'(fifo_empty), 1);
        check("drain_rdata", 32'(read_data), 0);
        check("drain_unf", 32'(fifo_underflow), 0);

        // Empty with simultaneous read and write: no bypass
        step(1'b1, 8'h33, 1'b1, 1'b0);
        check("unf_count", 32'(fifo_count), 1);
        check("unf_rdata", 32'(read_data), 32'h33);
        check("unf_empty", 32'(fifo_empty), 0);
        check("unf_flag", 32'(fifo_underflow), 32'(ERR_ON));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr", 32'(fifo_underflow), 0);
        check("unf_clr_count", 32'(fifo_count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_pop_empty", 32'(fifo_empty), 1);
        check("unf_pop_flag", 32'(fifo_underflow), 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("unf_setwins", 32'(fifo_underflow), 32'(ERR_ON));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr2", 32'(fifo_underflow), 0);

        // Random mix against a queue model, reset pulsed mid-burst
        for (int i = 0; i < 20; i++) begin
            we     = ($urandom_range(0, 9) < 7);
            re     = ($urandom_range(0, 9) < 4);
            wd     = 8'($urandom_range(0, 255));
            full_m = (q.size() == 8);
            wacc   = we && (!full_m || re);
            racc   = re && (q.size() > 0);
            exp_rd = (q.size() > 0) ? q[0] : 8'h00;
            check($sformatf("rnd%0d_rdata", i), 32'(read_data), 32'(exp_rd));
            step(we, wd, re, 1'b0);
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(wd);
            check($sformatf("rnd%0d_count", i), 32'(fifo_count), q.size());
            check($sformatf("rnd%0d_full", i), 32'(fifo_full), (q.size() == 8) ? 1 : 0);
            if (i == 10) begin
                #2 rst_n = 1'b0;
                #1 check_reset_state("midrst");
                @(negedge clk);
                rst_n = 1'b1;
                q.delete();
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: observed running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
